// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the four write requesters, the arbiter and the shared 10-bit FIFO.
// master: the arbiter side. slave: requesters/FIFO (or a testbench) side.
interface fifo_wr_arbiter_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [9:0]  fifo_din;
    logic        locked;
    logic [1:0]  owner;

    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_din,
        output locked,
        output owner
    );

    modport slave (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_din,
        input  locked,
        input  owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Four-way write arbiter in front of a shared FIFO.
// A writer keeps a burst lock for up to BURST consecutive words, then selection
// rotates round-robin starting after the last writer. Writes are zero-latency:
// the FIFO strobe and the requester accept strobe are combinational.
module fifo_wr_arbiter #(
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam logic [3:0] BURST_C = 4'(BURST);

    logic       lock_q, lock_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic [1:0] sel;
    logic       sel_vld;
    logic [1:0] scan_idx;
    logic       write;

    // Pick the requester: the lock holder while it stays valid, else round-robin scan.
    always_comb begin
        sel      = owner_q;
        sel_vld  = 1'b0;
        scan_idx = last_grant_q;
        if (lock_q && bus.req_valid[owner_q]) begin
            sel     = owner_q;
            sel_vld = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                scan_idx = last_grant_q + 2'(k);
                if (!sel_vld && bus.req_valid[scan_idx]) begin
                    sel     = scan_idx;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    assign write = rst && sel_vld && !bus.fifo_full;

    assign bus.fifo_wr_en = write;
    assign bus.req_ready  = write ? (4'b0001 << sel) : 4'b0000;
    assign bus.fifo_din   = write ? {sel, bus.req_data[{sel, 3'b000} +: 8]} : 10'd0;
    assign bus.locked     = lock_q;
    assign bus.owner      = owner_q;

    // Burst bookkeeping: extend or take over the lock on a write, release on
    // burst completion or when the holder goes idle (not while the FIFO is full).
    always_comb begin
        lock_d       = lock_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        if (write) begin
            last_grant_d = sel;
            if (lock_q && (sel == owner_q)) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
                lock_d      = 1'b1;
                owner_d     = sel;
                burst_cnt_d = 4'd1;
            end
            if (burst_cnt_d == BURST_C) begin
                lock_d      = 1'b0;
                burst_cnt_d = 4'd0;
            end
        end else if (lock_q && !bus.req_valid[owner_q] && !bus.fifo_full) begin
            lock_d      = 1'b0;
            burst_cnt_d = 4'd0;
        end
    end

    // State registers; reset leaves last_grant at 3 so requester 0 is scanned first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q       <= 1'b0;
            owner_q      <= 2'd0;
            burst_cnt_q  <= 4'd0;
            last_grant_q <= 2'd3;
        end else begin
            lock_q       <= lock_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: BURST=4 instance checked against a
// scoreboard of expected FIFO words; a BURST=1 instance on the same inputs
// must never show the lock and must write whenever anything is valid.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter_if bus0 ();
    fifo_wr_arbiter_if bus1 ();

    assign bus1.req_valid = bus0.req_valid;
    assign bus1.req_data  = bus0.req_data;
    assign bus1.fifo_full = bus0.fifo_full;

    fifo_wr_arbiter #(.BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    fifo_wr_arbiter #(.BURST(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    // One clock of stimulus: ew/eid = expected write this cycle and its source,
    // elk/eown = expected locked/owner after the edge.
    task automatic step(input logic r, input logic [3:0] v, input logic f,
                        input logic ew, input logic [1:0] eid,
                        input logic elk, input logic [1:0] eown);
        logic [9:0] exp_din;
        logic [31:0] d;
        exp_din = 10'd0;
        d = $urandom;
        rst = r;
        bus0.req_valid = v;
        bus0.fifo_full = f;
        bus0.req_data  = d;
        if (ew) exp_q.push_back({eid, d[{eid, 3'b000} +: 8]});
        @(negedge clk);
        checks++;
        assert (bus0.fifo_wr_en === ew) else begin
            errors++;
            $error("FAIL wr_en got %b exp %b at %0t", bus0.fifo_wr_en, ew, $time);
        end
        if (ew) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty got size 0 exp >0 at %0t", $time);
            end
            if (exp_q.size() != 0) exp_din = exp_q.pop_front();
            checks++;
            assert (bus0.fifo_din === exp_din) else begin
                errors++;
                $error("FAIL din got %h exp %h at %0t", bus0.fifo_din, exp_din, $time);
            end
            checks++;
            assert (bus0.req_ready === (4'b0001 << exp_din[9:8])) else begin
                errors++;
                $error("FAIL ready got %b exp %b at %0t", bus0.req_ready,
                       4'b0001 << exp_din[9:8], $time);
            end
        end else begin
            checks++;
            assert (bus0.req_ready === 4'b0000 && bus0.fifo_din === 10'd0) else begin
                errors++;
                $error("FAIL idle_out got ready %b din %h exp 0/0 at %0t",
                       bus0.req_ready, bus0.fifo_din, $time);
            end
        end
        checks++;
        assert (bus1.fifo_wr_en === (r & (|v) & ~f)) else begin
            errors++;
            $error("FAIL b1_wr_en got %b exp %b at %0t", bus1.fifo_wr_en,
                   r & (|v) & ~f, $time);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (bus0.locked === elk) else begin
            errors++;
            $error("FAIL locked got %b exp %b at %0t", bus0.locked, elk, $time);
        end
        checks++;
        assert (bus0.owner === eown) else begin
            errors++;
            $error("FAIL owner got %0d exp %0d at %0t", bus0.owner, eown, $time);
        end
        checks++;
        assert (bus1.locked === 1'b0) else begin
            errors++;
            $error("FAIL b1_locked got %b exp 0 at %0t", bus1.locked, $time);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus0.req_valid = 4'b0000;
        bus0.req_data  = 32'd0;
        bus0.fifo_full = 1'b0;

        // Reset with everyone valid: nothing written; then requester 0 first.
        step(0, 4'b1111, 0, 0, 2'd0, 0, 2'd0);
        step(0, 4'b1111, 0, 0, 2'd0, 0, 2'd0);
        step(1, 4'b1111, 0, 1, 2'd0, 1, 2'd0);

        // Two requesters held valid: 4x id0, 4x id1, 4x id0.
        step(0, 4'b0000, 0, 0, 2'd0, 0, 2'd0);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin
                step(1, 4'b0011, 0, 1, 2'(b % 2), (i != 3), 2'(b % 2));
            end
        end

        // id0 burst stalled 3 cycles by a full FIFO, then resumes and rotates.
        step(0, 4'b0000, 0, 0, 2'd0, 0, 2'd0);
        step(1, 4'b0011, 0, 1, 2'd0, 1, 2'd0);
        step(1, 4'b0011, 0, 1, 2'd0, 1, 2'd0);
        for (int i = 0; i < 3; i++) step(1, 4'b0011, 1, 0, 2'd0, 1, 2'd0);
        step(1, 4'b0011, 0, 1, 2'd0, 1, 2'd0);
        step(1, 4'b0011, 0, 1, 2'd0, 0, 2'd0);
        step(1, 4'b0011, 0, 1, 2'd1, 1, 2'd1);

        // Lock holder drops out while only id3 is valid: id3 takes over the lock.
        step(0, 4'b0000, 0, 0, 2'd0, 0, 2'd0);
        step(1, 4'b0001, 0, 1, 2'd0, 1, 2'd0);
        step(1, 4'b1000, 0, 1, 2'd3, 1, 2'd3);
        // Holder idle with nothing else valid: lock released, owner kept.
        step(1, 4'b0000, 0, 0, 2'd0, 0, 2'd3);

        // Lone requester id2 writes every cycle, re-acquiring the lock.
        step(0, 4'b0000, 0, 0, 2'd0, 0, 2'd0);
        for (int i = 0; i < 8; i++) step(1, 4'b0100, 0, 1, 2'd2, ((i % 4) != 3), 2'd2);

        // Reset mid-burst of id1; afterwards scan restarts at 0 so id1 wins over id2.
        step(0, 4'b0000, 0, 0, 2'd0, 0, 2'd0);
        step(1, 4'b0010, 0, 1, 2'd1, 1, 2'd1);
        step(1, 4'b0010, 0, 1, 2'd1, 1, 2'd1);
        step(0, 4'b0010, 0, 0, 2'd0, 0, 2'd0);
        step(1, 4'b0110, 0, 1, 2'd1, 1, 2'd1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover got %0d exp 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
